// File: rtl/shot_controller.sv
// Battleship shot resolver: edge-detects fire, drives the board mux, classifies hit/miss/repeat.
// Optional shot budget (lose condition) enabled by defining SHOT_LIMIT_EN.
module shot_controller #(
  parameter int SHIP_CELLS = 10,
  parameter int MAX_SHOTS  = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic       cell_data,
  output logic [5:0] sel,
  output logic       busy,
  output logic       hit,
  output logic       miss,
  output logic       repeat_shot,
  output logic [6:0] shots,
  output logic [5:0] hits,
  output logic       win,
  output logic       lose
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_nx;

  logic        fire_q, armed, rise, fresh, win_nx, lose_nx;
  logic [63:0] mask;
  logic [6:0]  shots_nx;
  logic [5:0]  hits_nx;

  // armed blocks a level already high at reset release from looking like an edge
  assign rise     = fire & ~fire_q & armed;
  assign fresh    = ~mask[sel];
  assign shots_nx = shots + 7'(fresh);
  assign hits_nx  = hits + 6'(fresh & cell_data);
  assign win_nx   = (hits_nx == 6'(SHIP_CELLS));

`ifdef SHOT_LIMIT_EN
  logic lose_q;
  assign lose_nx = ~win_nx & (shots_nx == 7'(MAX_SHOTS));
  assign lose    = lose_q;
  always_ff @(posedge clk or posedge reset)
    if (reset)                       lose_q <= 1'b0;
    else if (state == SAMPLE && lose_nx) lose_q <= 1'b1;
`else
  assign lose_nx = 1'b0;
  assign lose    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE:   if (rise) state_nx = SETTLE;
      SETTLE: begin busy = 1'b1; state_nx = SAMPLE; end
      SAMPLE: begin
        busy     = 1'b1;
        state_nx = (win_nx || lose_nx) ? DONE : IDLE;
      end
      default: state_nx = DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fire_q      <= 1'b0;
      armed       <= 1'b0;
      sel         <= '0;
      mask        <= '0;
      shots       <= '0;
      hits        <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      repeat_shot <= 1'b0;
      win         <= 1'b0;
    end else begin
      fire_q      <= fire;
      armed       <= 1'b1;
      hit         <= 1'b0;
      miss        <= 1'b0;
      repeat_shot <= 1'b0;
      if (state == IDLE && rise) sel <= {row, col};
      if (state == SAMPLE) begin
        if (!fresh) repeat_shot <= 1'b1;
        else begin
          mask[sel] <= 1'b1;
          shots     <= shots_nx;
          hits      <= hits_nx;
          hit       <= cell_data;
          miss      <= ~cell_data;
        end
        if (win_nx) win <= 1'b1;
      end
    end
endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller built with SHIP_CELLS=3, MAX_SHOTS=4.
module tb_shot_controller;
  logic       clk, reset, fire, cell_data;
  logic [2:0] row, col;
  logic [5:0] sel;
  logic       busy, hit, miss, repeat_shot, win, lose;
  logic [6:0] shots;
  logic [5:0] hits;

  int compared = 0;
  int mismatched = 0;

  localparam logic [2:0] P_NONE = 3'b000, P_HIT = 3'b100, P_MISS = 3'b010, P_REP = 3'b001;
`ifdef SHOT_LIMIT_EN
  localparam logic LIMIT = 1'b1;
`else
  localparam logic LIMIT = 1'b0;
`endif

  shot_controller #(.SHIP_CELLS(3), .MAX_SHOTS(4)) dut (
    .clk(clk), .reset(reset), .fire(fire), .row(row), .col(col), .cell_data(cell_data),
    .sel(sel), .busy(busy), .hit(hit), .miss(miss), .repeat_shot(repeat_shot),
    .shots(shots), .hits(hits), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".sel"}, int'(sel), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".pulses"}, int'({hit, miss, repeat_shot}), 0);
    chk({tag, ".shots"}, int'(shots), 0);
    chk({tag, ".hits"}, int'(hits), 0);
    chk({tag, ".winlose"}, int'({win, lose}), 0);
  endtask

  // Fire at (r,c), hold fire for 'hold' cycles, check latency, busy window and pulse count.
  task automatic do_shot(input string tag, input logic [2:0] r, input logic [2:0] c,
                         input logic d, input logic [2:0] expp, input int hold);
    int npulse = 0;
    @(negedge clk);
    row = r; col = c; cell_data = d; fire = 1'b1;
    for (int i = 0; i < hold + 4; i++) begin
      @(posedge clk); #1;
      if ({hit, miss, repeat_shot} != 3'b000) npulse++;
      if (i == 0) begin
        chk({tag, ".busy0"}, int'(busy), int'(expp != P_NONE));
        if (expp != P_NONE) chk({tag, ".sel"}, int'(sel), int'({r, c}));
      end
      if (i == 1) chk({tag, ".busy1"}, int'(busy), int'(expp != P_NONE));
      if (i == 2) begin
        chk({tag, ".pulse"}, int'({hit, miss, repeat_shot}), int'(expp));
        chk({tag, ".busy2"}, int'(busy), 0);
      end
      if (i == hold - 1) fire = 1'b0;
    end
    chk({tag, ".npulse"}, npulse, int'(expp != P_NONE));
  endtask

  task automatic pulse_reset;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0; row = '0; col = '0; cell_data = 1'b0;
    #2 chk_all_zero("reset");
    // fire already high when reset releases must not start a shot
    @(negedge clk); fire = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("fire_at_release.busy", int'(busy), 0);
    chk("fire_at_release.shots", int'(shots), 0);
    @(negedge clk); fire = 1'b0;

    do_shot("hit25", 3'd2, 3'd5, 1'b1, P_HIT, 1);
    chk("hit25.shots", int'(shots), 1);
    chk("hit25.hits", int'(hits), 1);
    do_shot("rep25", 3'd2, 3'd5, 1'b1, P_REP, 1);
    chk("rep25.shots", int'(shots), 1);
    chk("rep25.hits", int'(hits), 1);
    do_shot("hold33", 3'd3, 3'd3, 1'b0, P_MISS, 10);
    chk("hold33.shots", int'(shots), 2);
    chk("hold33.sel_holds", int'(sel), int'(6'b011011));

    // four distinct misses: budget exhausted only when the limit is built in
    pulse_reset();
    for (int k = 0; k < 4; k++) do_shot("budget", 3'd0, 3'(k), 1'b0, P_MISS, 1);
    chk("budget.shots", int'(shots), 4);
    chk("budget.lose", int'(lose), int'(LIMIT));
    chk("budget.win", int'(win), 0);
    do_shot("after_budget", 3'd0, 3'd4, 1'b0, LIMIT ? P_NONE : P_MISS, 1);
    chk("after_budget.shots", int'(shots), LIMIT ? 4 : 5);

    // reset asserted while the shot is in SETTLE
    @(negedge clk); row = 3'd1; col = 3'd1; cell_data = 1'b0; fire = 1'b1;
    @(posedge clk); #1 chk("midshot.busy", int'(busy), 1);
    reset = 1'b1;
    #1 chk_all_zero("midshot_reset");
    @(negedge clk); reset = 1'b0; fire = 1'b0;
    @(negedge clk);
    do_shot("post_abort", 3'd1, 3'd1, 1'b0, P_MISS, 1);
    chk("post_abort.shots", int'(shots), 1);

    // win on shot 4 coincides with budget exhaustion: win must take priority
    pulse_reset();
    do_shot("w_miss", 3'd7, 3'd7, 1'b0, P_MISS, 1);
    do_shot("w_hit0", 3'd4, 3'd0, 1'b1, P_HIT, 1);
    do_shot("w_hit1", 3'd4, 3'd1, 1'b1, P_HIT, 1);
    chk("w_mid.win", int'(win), 0);
    do_shot("w_hit2", 3'd4, 3'd2, 1'b1, P_HIT, 1);
    chk("win.win", int'(win), 1);
    chk("win.lose", int'(lose), 0);
    chk("win.hits", int'(hits), 3);
    chk("win.shots", int'(shots), 4);
    do_shot("done_fire", 3'd5, 3'd5, 1'b1, P_NONE, 1);
    chk("done.shots", int'(shots), 4);
    chk("done.hits", int'(hits), 3);
    chk("done.sel", int'(sel), int'(6'b100010));
    chk("done.win", int'(win), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 The block SHALL have parameter SHIP_CELLS, default 10: number of occupied board cells that must be hit to win (1..63).
REQ-002 The block SHALL have parameter MAX_SHOTS, default 40: shot budget, used only when SHOT_LIMIT_EN is defined (1..64).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port fire  input  1  level from the debounced fire button; a 0->1 transition requests a shot.
REQ-006 The block SHALL have port row  input  3  target row, A..H = 0..7.
REQ-007 The block SHALL have port col  input  3  target column, 0..7.
REQ-008 The block SHALL have port cell_data  input  1  X output of the external 64:1 board mux; 1 means ship present.
REQ-009 The block SHALL have port sel  output  6  board-mux select; sel[5:3] drives S5..S3 (row), sel[2:0] drives S2..S0 (column).
REQ-010 The block SHALL have port busy  output  1  high while a shot is being resolved.
REQ-011 The block SHALL have port hit  output  1  one-cycle pulse: new shot landed on a ship cell.
REQ-012 The block SHALL have port miss  output  1  one-cycle pulse: new shot landed on water.
REQ-013 The block SHALL have port repeat_shot  output  1  one-cycle pulse: target cell was already fired on; no counters change.
REQ-014 The block SHALL have port shots  output  7  count of distinct cells fired on.
REQ-015 The block SHALL have port hits  output  6  count of distinct ship cells hit.
REQ-016 The block SHALL have port win  output  1  sticky; hits reached SHIP_CELLS.
REQ-017 The block SHALL have port lose  output  1  sticky; shot budget exhausted without a win.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-019 A registered copy of fire SHALL give edge detection: rising edge = fire & ~fire_q; a level held high SHALL NOT fire again.
REQ-020 In IDLE, on a rising edge: sel <= {row,col}, next state SETTLE; rising edges seen in any other state SHALL be ignored, not queued.
REQ-021 SETTLE SHALL last exactly one cycle and then go to SAMPLE, giving the mux one full cycle to settle.
REQ-022 In SAMPLE, the block SHALL sample cell_data and read a 64-bit fired mask at index sel.
REQ-023 If the mask bit is set: pulse repeat_shot; counters SHALL be unchanged.
REQ-024 If the mask bit is clear: set the mask bit and increment shots; if cell_data=1, increment hits and pulse hit, else pulse miss.
REQ-025 Latency: a rising edge sampled at clock edge N SHALL give a hit/miss/repeat_shot pulse high between edges N+2 and N+3.
REQ-026 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-027 After SAMPLE, the next state SHALL be DONE if the updated hits = SHIP_CELLS (win <= 1); otherwise DONE if the budget is exhausted (lose <= 1); otherwise IDLE.
REQ-028 If win and lose conditions coincide on the same shot, win SHALL take priority and lose SHALL stay 0.
REQ-029 DONE SHALL be terminal until reset; fire SHALL be ignored and sel, shots and hits SHALL hold.
REQ-030 hit, miss and repeat_shot SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-031 sel SHALL hold its last latched value between shots.

Reset
REQ-032 While reset=1, regardless of clk: state=IDLE; sel, shots, hits, mask and fire_q all =0; busy, hit, miss, repeat_shot, win and lose all =0.
REQ-033 Reset asserted mid-shot (SETTLE/SAMPLE) SHALL abort the shot with no counter or mask update and no pulse.
REQ-034 If fire is high when reset deasserts, it SHALL NOT trigger a shot; fire_q is loaded from fire on the first clock after reset.

Configuration
REQ-035 The macro SHOT_LIMIT_EN SHALL control the shot-budget feature.
REQ-036 With SHOT_LIMIT_EN defined, the budget is exhausted when shots = MAX_SHOTS after a SAMPLE update, and this SHALL set lose.
REQ-037 Without SHOT_LIMIT_EN, lose SHALL be tied to 0, MAX_SHOTS SHALL be unused, and the game SHALL end only on win (shots max 64).

Verification
REQ-038 Reset, then row=2, col=5 with cell_data=1 and a fire pulse -> sel=6'b010101 one cycle later, busy high for 2 cycles, hit pulse at N+2, shots=1, hits=1.
REQ-039 Fire the same cell again -> repeat_shot pulse only; shots=1, hits=1 unchanged.
REQ-040 Hold fire high for 10 cycles on a new cell with cell_data=0 -> exactly one miss pulse; shots=2.
REQ-041 SHIP_CELLS=3: three distinct hits -> win=1 after the third pulse, state DONE; a further fire -> no pulse, counters hold.
REQ-042 SHOT_LIMIT_EN defined, MAX_SHOTS=4: four distinct misses -> lose=1; with the macro undefined, the same stimulus -> lose=0 and the block returns to IDLE.
REQ-043 Assert reset during SETTLE -> all outputs 0 immediately (asynchronously); the next shot afterward shows shots=1.
